// File: rtl/pass_enable_sequencer.sv
// ============================================================================
//  Module   : pass_enable_sequencer
//  Brief    : Break-before-make enable sequencer for a bank of pass-switch bus
//             segments. Optional auto-release timer: PASS_SEQ_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pass_enable_sequencer #(
    parameter int NUM_SEG        = 4,
    parameter int SEG_W          = 2,
    parameter int DEAD_CYCLES    = 2,
    parameter int SETTLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [SEG_W-1:0]   req_seg,
    input  logic               req_off,
    output logic [NUM_SEG-1:0] en,
    output logic [SEG_W-1:0]   cur_seg,
    output logic               connected,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               timeout
);

    localparam int C_MAX_DS  = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
    localparam int C_CNT_MAX = (C_MAX_DS > TIMEOUT_CYCLES) ? C_MAX_DS : TIMEOUT_CYCLES;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

    localparam logic [SEG_W:0]   C_NUM_SEG    = (SEG_W+1)'(NUM_SEG);
    localparam logic [C_CNT_W-1:0] C_DEAD_LD   = C_CNT_W'(DEAD_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_SETTLE_LD = C_CNT_W'(SETTLE_CYCLES - 1);
`ifdef PASS_SEQ_TIMEOUT_EN
    localparam logic [C_CNT_W-1:0] C_TMO_LD    = C_CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DEAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CONN   = 2'd3
    } state_t;

    state_t               r_state, w_nxt_state;
    logic [NUM_SEG-1:0]   r_en, w_nxt_en;
    logic [C_CNT_W-1:0]   r_cnt, w_nxt_cnt;
    logic [SEG_W-1:0]     r_cur_seg, w_nxt_cur_seg;
    logic [SEG_W-1:0]     r_tgt_seg, w_nxt_tgt_seg;
    logic                 r_tgt_off, w_nxt_tgt_off;
    logic                 r_silent, w_nxt_silent;
    logic                 r_done, w_nxt_done;
    logic                 r_err, w_nxt_err;

    logic                 w_accept;
    logic                 w_bad;
    logic [NUM_SEG-1:0]   w_req_oh;
    logic [NUM_SEG-1:0]   w_tgt_oh;

    assign req_ready = (r_state == ST_IDLE) || (r_state == ST_CONN);
    assign busy      = (r_state == ST_DEAD) || (r_state == ST_SETTLE);
    assign connected = (r_state == ST_CONN);
    assign en        = r_en;
    assign cur_seg   = r_cur_seg;
    assign done      = r_done;
    assign err       = r_err;

    assign w_accept = req_valid && req_ready;
    assign w_bad    = !req_off && ({1'b0, req_seg} >= C_NUM_SEG);
    assign w_req_oh = NUM_SEG'(1) << req_seg;
    assign w_tgt_oh = NUM_SEG'(1) << r_tgt_seg;

`ifdef PASS_SEQ_TIMEOUT_EN
    logic r_tmo, w_nxt_tmo;
    assign timeout = r_tmo;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_en      <= '0;
            r_cnt     <= '0;
            r_cur_seg <= '0;
            r_tgt_seg <= '0;
            r_tgt_off <= 1'b0;
            r_silent  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef PASS_SEQ_TIMEOUT_EN
            r_tmo     <= 1'b0;
`endif
        end else begin
            r_state   <= w_nxt_state;
            r_en      <= w_nxt_en;
            r_cnt     <= w_nxt_cnt;
            r_cur_seg <= w_nxt_cur_seg;
            r_tgt_seg <= w_nxt_tgt_seg;
            r_tgt_off <= w_nxt_tgt_off;
            r_silent  <= w_nxt_silent;
            r_done    <= w_nxt_done;
            r_err     <= w_nxt_err;
`ifdef PASS_SEQ_TIMEOUT_EN
            r_tmo     <= w_nxt_tmo;
`endif
        end
    end

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_en      = r_en;
        w_nxt_cnt     = r_cnt;
        w_nxt_cur_seg = r_cur_seg;
        w_nxt_tgt_seg = r_tgt_seg;
        w_nxt_tgt_off = r_tgt_off;
        w_nxt_silent  = r_silent;
        w_nxt_done    = 1'b0;
        w_nxt_err     = 1'b0;
`ifdef PASS_SEQ_TIMEOUT_EN
        w_nxt_tmo     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_bad) begin
                        w_nxt_err  = 1'b1;
                        w_nxt_done = 1'b1;
                    end else if (req_off) begin
                        w_nxt_done = 1'b1;
                    end else begin
                        // Nothing is driving the bus, so make immediately.
                        w_nxt_state   = ST_SETTLE;
                        w_nxt_en      = w_req_oh;
                        w_nxt_tgt_seg = req_seg;
                        w_nxt_cnt     = C_SETTLE_LD;
                    end
                end
            end
            ST_DEAD: begin
                if (r_cnt == '0) begin
                    if (r_tgt_off) begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_done  = !r_silent;
                    end else begin
                        w_nxt_state = ST_SETTLE;
                        w_nxt_en    = w_tgt_oh;
                        w_nxt_cnt   = C_SETTLE_LD;
                    end
                end else begin
                    w_nxt_cnt = r_cnt - 1'b1;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_nxt_state   = ST_CONN;
                    w_nxt_done    = 1'b1;
                    w_nxt_cur_seg = r_tgt_seg;
`ifdef PASS_SEQ_TIMEOUT_EN
                    w_nxt_cnt     = C_TMO_LD;
`endif
                end else begin
                    w_nxt_cnt = r_cnt - 1'b1;
                end
            end
            ST_CONN: begin
                if (w_accept) begin
                    if (w_bad) begin
                        w_nxt_err  = 1'b1;
                        w_nxt_done = 1'b1;
`ifdef PASS_SEQ_TIMEOUT_EN
                        w_nxt_cnt  = C_TMO_LD;
`endif
                    end else if (!req_off && (req_seg == r_cur_seg)) begin
                        w_nxt_done = 1'b1;
`ifdef PASS_SEQ_TIMEOUT_EN
                        w_nxt_cnt  = C_TMO_LD;
`endif
                    end else begin
                        // Break first; DEAD decides whether to make a new segment.
                        w_nxt_state   = ST_DEAD;
                        w_nxt_en      = '0;
                        w_nxt_cnt     = C_DEAD_LD;
                        w_nxt_tgt_seg = req_seg;
                        w_nxt_tgt_off = req_off;
                        w_nxt_silent  = 1'b0;
                    end
                end
`ifdef PASS_SEQ_TIMEOUT_EN
                else if (r_cnt == '0) begin
                    w_nxt_tmo     = 1'b1;
                    w_nxt_state   = ST_DEAD;
                    w_nxt_en      = '0;
                    w_nxt_cnt     = C_DEAD_LD;
                    w_nxt_tgt_off = 1'b1;
                    w_nxt_silent  = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt - 1'b1;
                end
`endif
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_en    = '0;
            end
        endcase
    end

endmodule

`default_nettype wire
